servo_ramp_pwm: RTL and testbench

Parametrised multi-channel hobby-servo PWM generator, successor to the single-channel fixed open/close servo driver.
- Drives N_CH servo outputs from one shared 20 ms frame counter.
- Each channel has a writable target pulse width.
- The applied pulse width ramps toward the target by at most STEP cycles per frame, giving slew-limited motion.
- Sits between the button/UART command logic and the servo pins.

---
 rtl/servo_pkg.sv | 20 ++
 rtl/servo_ramp_ch.sv | 81 ++++++++
 rtl/servo_ramp_pwm.sv | 99 +++++++++
 tb/tb_servo_ramp_pwm.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared servo timing constants for a 12 MHz system clock, plus a small
// helper for sizing channel index ports.
//   T_20MS                   : one servo frame in cycles
//   POS_1MS/POS_1P5MS/POS_2MS : standard pulse widths (full left/centre/right)
//   POS_OPEN/POS_CLOSE       : default positions used by the button logic
package servo_pkg;

    localparam int unsigned T_20MS    = 240000;
    localparam int unsigned POS_1MS   = 12000;
    localparam int unsigned POS_1P5MS = 18000;
    localparam int unsigned POS_2MS   = 24000;
    localparam int unsigned POS_OPEN  = POS_2MS;
    localparam int unsigned POS_CLOSE = POS_1MS;

    // Width of a channel index, never less than one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/servo_ramp_ch.sv
// One servo channel: target and applied pulse-width registers, slew-limited
// ramp toward the target once per frame, and registered PWM/moving outputs.
//   clk, rst   : clock, asynchronous active-high reset
//   ena_i      : global enable, gates the PWM output
//   cnt_i      : shared frame counter
//   upd_i      : last cycle of an enabled frame, applies one ramp step
//   wr_i       : load a new target (clamped) from wr_pos_i
//   servo_o    : PWM output, high while cnt < applied width (one cycle late)
//   moving_o   : high while applied width differs from target
module servo_ramp_ch
    import servo_pkg::*;
#(
    parameter int unsigned POS_W   = 18,
    parameter int unsigned POS_MIN = POS_1MS,
    parameter int unsigned POS_MAX = POS_2MS,
    parameter int unsigned POS_RST = POS_1P5MS,
    parameter int unsigned STEP    = 120
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena_i,
    input  logic [POS_W-1:0] cnt_i,
    input  logic             upd_i,
    input  logic             wr_i,
    input  logic [POS_W-1:0] wr_pos_i,
    output logic             servo_o,
    output logic             moving_o
);

    localparam logic [POS_W-1:0] PosMin  = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] PosMax  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] PosRst  = POS_W'(POS_RST);
    localparam logic [POS_W-1:0] StepLim = POS_W'(STEP);

    logic [POS_W-1:0] tgt_q, tgt_d;
    logic [POS_W-1:0] cur_q, cur_d;
    logic [POS_W-1:0] wr_clamped;
    logic             servo_q, moving_q;

    always_comb begin
        wr_clamped = wr_pos_i;
        if (wr_pos_i < PosMin) begin
            wr_clamped = PosMin;
        end else if (wr_pos_i > PosMax) begin
            wr_clamped = PosMax;
        end

        tgt_d = wr_i ? wr_clamped : tgt_q;

        // Ramp against the pre-write target; compare distances rather than
        // forming cur +/- STEP first so the subtract cannot wrap.
        cur_d = cur_q;
        if (upd_i) begin
            if (STEP == 0) begin
                cur_d = tgt_q;
            end else if (cur_q < tgt_q) begin
                cur_d = ((tgt_q - cur_q) > StepLim) ? cur_q + StepLim : tgt_q;
            end else if (cur_q > tgt_q) begin
                cur_d = ((cur_q - tgt_q) > StepLim) ? cur_q - StepLim : tgt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q    <= PosRst;
            cur_q    <= PosRst;
            servo_q  <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            tgt_q    <= tgt_d;
            cur_q    <= cur_d;
            servo_q  <= ena_i && (cnt_i < cur_q);
            moving_q <= (cur_q != tgt_q);
        end
    end

    assign servo_o  = servo_q;
    assign moving_o = moving_q;

endmodule

// File: rtl/servo_ramp_pwm.sv
// Multi-channel hobby-servo PWM generator with per-frame slew limiting.
// One shared frame counter drives N_CH servo_ramp_ch instances.
//   clk, rst   : clock, asynchronous active-high reset
//   ena        : global enable; low forces outputs low, holds cnt at 0
//   wr_en      : write strobe; wr_ch selects channel, wr_pos the new target
//   servo      : PWM outputs, one per channel
//   moving     : per-channel "applied width != target"
//   frame_tick : one-cycle pulse aligned with the first high PWM cycle
module servo_ramp_pwm
    import servo_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CH_W       = ch_idx_w(N_CH),
    parameter int unsigned POS_W      = 18,
    parameter int unsigned PERIOD_CYC = T_20MS,
    parameter int unsigned POS_MIN    = POS_1MS,
    parameter int unsigned POS_MAX    = POS_2MS,
    parameter int unsigned POS_RST    = POS_1P5MS,
    parameter int unsigned STEP       = 120
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [POS_W-1:0] wr_pos,
    output logic [N_CH-1:0]  servo,
    output logic [N_CH-1:0]  moving,
    output logic             frame_tick
);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("servo_ramp_pwm: N_CH must be 1..16");
    end
    if (CH_W < ch_idx_w(N_CH)) begin : g_bad_chw
        $error("servo_ramp_pwm: CH_W too narrow for N_CH");
    end
    if (!(POS_MIN <= POS_RST && POS_RST <= POS_MAX && POS_MAX < PERIOD_CYC)) begin : g_bad_pos
        $error("servo_ramp_pwm: need POS_MIN <= POS_RST <= POS_MAX < PERIOD_CYC");
    end
    if ((64'(PERIOD_CYC) - 64'd1) >= (64'd1 << POS_W)) begin : g_bad_period
        $error("servo_ramp_pwm: PERIOD_CYC-1 does not fit in POS_W");
    end
    if ((64'(POS_MAX) + 64'(STEP)) >= (64'd1 << POS_W)) begin : g_bad_step
        $error("servo_ramp_pwm: POS_MAX+STEP does not fit in POS_W");
    end

    localparam logic [POS_W-1:0] CntLast = POS_W'(PERIOD_CYC - 1);

    logic [POS_W-1:0] cnt_q, cnt_d;
    logic             frame_tick_q;
    logic             upd;

    assign upd = ena && (cnt_q == CntLast);

    always_comb begin
        cnt_d = '0;
        if (ena && (cnt_q != CntLast)) begin
            cnt_d = cnt_q + POS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            frame_tick_q <= ena && (cnt_q == '0);
        end
    end

    assign frame_tick = frame_tick_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Equality against an in-range index also drops wr_ch >= N_CH.
        logic wr_sel;
        assign wr_sel = wr_en && (32'(wr_ch) == 32'(i));

        servo_ramp_ch #(
            .POS_W   (POS_W),
            .POS_MIN (POS_MIN),
            .POS_MAX (POS_MAX),
            .POS_RST (POS_RST),
            .STEP    (STEP)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .ena_i    (ena),
            .cnt_i    (cnt_q),
            .upd_i    (upd),
            .wr_i     (wr_sel),
            .wr_pos_i (wr_pos),
            .servo_o  (servo[i]),
            .moving_o (moving[i])
        );
    end

endmodule

// File: tb/tb_servo_ramp_pwm.sv
// Bench for servo_ramp_pwm: a STEP=5 build (3-bit channel index) and a STEP=0
// build share clock, reset and enable. A frame-level model predicts every
// output each cycle; measured pulse widths are also checked against
// hand-computed literals.
module tb_servo_ramp_pwm;

    localparam int NCh    = 4;
    localparam int Period = 100;
    localparam int PMin   = 10;
    localparam int PMax   = 50;
    localparam int PRst   = 30;
    localparam int PW     = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_ch = '0;
    logic [PW-1:0] wr_pos = '0;
    logic          wr0_en = 1'b0;
    logic [1:0]    wr0_ch = '0;
    logic [PW-1:0] wr0_pos = '0;

    logic [NCh-1:0] servo_a, moving_a, servo_b, moving_b;
    logic           tick_a, tick_b;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    servo_ramp_pwm #(
        .N_CH(NCh), .CH_W(3), .POS_W(PW), .PERIOD_CYC(Period),
        .POS_MIN(PMin), .POS_MAX(PMax), .POS_RST(PRst), .STEP(5)
    ) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_pos(wr_pos), .servo(servo_a), .moving(moving_a), .frame_tick(tick_a)
    );

    servo_ramp_pwm #(
        .N_CH(NCh), .POS_W(PW), .PERIOD_CYC(Period),
        .POS_MIN(PMin), .POS_MAX(PMax), .POS_RST(PRst), .STEP(0)
    ) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .wr_en(wr0_en), .wr_ch(wr0_ch),
        .wr_pos(wr0_pos), .servo(servo_b), .moving(moving_b), .frame_tick(tick_b)
    );

    // ---------------- model: frame position, targets, applied widths ----------
    int m_step [2] = '{5, 0};
    int m_cnt = 0;
    int m_tgt [2][NCh] = '{default: PRst};
    int m_cur [2][NCh] = '{default: PRst};
    bit m_servo [2][NCh] = '{default: 1'b0};
    bit m_moving [2][NCh] = '{default: 1'b0};
    bit m_tick = 1'b0;

    function automatic int clampi(input int v);
        return (v < PMin) ? PMin : ((v > PMax) ? PMax : v);
    endfunction

    function automatic int ramp(input int c, input int t, input int s);
        if (s == 0) return t;
        if (c < t) return (c + s < t) ? c + s : t;
        if (c > t) return (c - s > t) ? c - s : t;
        return c;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt    <= 0;
            m_tgt    <= '{default: PRst};
            m_cur    <= '{default: PRst};
            m_servo  <= '{default: 1'b0};
            m_moving <= '{default: 1'b0};
            m_tick   <= 1'b0;
        end else begin
            m_tick <= ena && (m_cnt == 0);
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NCh; i++) begin
                    m_servo[k][i]  <= ena && (m_cnt < m_cur[k][i]);
                    m_moving[k][i] <= (m_cur[k][i] != m_tgt[k][i]);
                    if (ena && m_cnt == Period - 1)
                        m_cur[k][i] <= ramp(m_cur[k][i], m_tgt[k][i], m_step[k]);
                end
            end
            if (wr_en && int'(wr_ch) < NCh) m_tgt[0][wr_ch] <= clampi(int'(wr_pos));
            if (wr0_en) m_tgt[1][wr0_ch] <= clampi(int'(wr0_pos));
            m_cnt <= ena ? (m_cnt + 1) % Period : 0;
        end
    end

    logic [NCh-1:0] es_a, em_a, es_b, em_b;
    always_comb begin
        es_a = '0; em_a = '0; es_b = '0; em_b = '0;
        for (int i = 0; i < NCh; i++) begin
            es_a[i] = m_servo[0][i];
            em_a[i] = m_moving[0][i];
            es_b[i] = m_servo[1][i];
            em_b[i] = m_moving[1][i];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("servo_a", 32'(servo_a), 32'(es_a));
            check("moving_a", 32'(moving_a), 32'(em_a));
            check("tick_a", 32'(tick_a), 32'(m_tick));
            check("servo_b", 32'(servo_b), 32'(es_b));
            check("moving_b", 32'(moving_b), 32'(em_b));
            check("tick_b", 32'(tick_b), 32'(m_tick));
        end
    end

    // ---------------- directed helpers ---------------------------------------
    int meas [2][NCh];

    // Count high cycles per channel over the 100 samples starting at a tick.
    task automatic measure();
        int n = 0;
        while (tick_a !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("tick_timeout", 32'd0, 32'd1);
        meas = '{default: 0};
        for (int c = 0; c < Period; c++) begin
            if (c > 0) @(negedge clk);
            for (int i = 0; i < NCh; i++) begin
                meas[0][i] += int'(servo_a[i]);
                meas[1][i] += int'(servo_b[i]);
            end
        end
    endtask

    task automatic wchk(input string name, input int k, input int i, input int exp);
        check($sformatf("%s_w%0d_ch%0d", name, k, i), 32'(meas[k][i]), 32'(exp));
    endtask

    task automatic write_a(input int ch, input int pos);
        wr_en = 1'b1; wr_ch = 3'(ch); wr_pos = PW'(pos);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_cnt(input int c);
        int n = 0;
        while (m_cnt != c && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("cnt_timeout", 32'd0, 32'd1);
    endtask

    int exp1 [5] = '{35, 40, 45, 50, 50};
    int exp2 [5] = '{25, 20, 15, 10, 10};
    int exp3 [5] = '{35, 40, 45, 50, 50};
    int exp0 [4] = '{30, 35, 40, 42};

    initial begin
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        rst = 1'b0;
        ena = 1'b1;

        // Idle: every channel 30 wide, nothing moving.
        measure();
        for (int i = 0; i < NCh; i++) begin
            wchk("idle", 0, i, 30);
            wchk("idle", 1, i, 30);
        end
        check("idle_moving", 32'(moving_a), 32'd0);

        // Mid-frame write ch1=50 (STEP=5), and ch0=12 on the STEP=0 build.
        repeat (20) @(negedge clk);
        wr0_en = 1'b1; wr0_ch = 2'd0; wr0_pos = 8'd12;
        write_a(1, 50);
        wr0_en = 1'b0;
        for (int f = 0; f < 5; f++) begin
            measure();
            wchk($sformatf("up_f%0d", f), 0, 1, exp1[f]);
            wchk($sformatf("up_f%0d", f), 0, 0, 30);
            wchk($sformatf("jump_f%0d", f), 1, 0, 12);
        end
        check("up_moving_done", 32'(moving_a[1]), 32'd0);

        // Clamped targets: ch2=3 -> 10, ch3=200 -> 50.
        repeat (20) @(negedge clk);
        write_a(2, 3);
        write_a(3, 200);
        for (int f = 0; f < 5; f++) begin
            measure();
            wchk($sformatf("clamp_f%0d", f), 0, 2, exp2[f]);
            wchk($sformatf("clamp_f%0d", f), 0, 3, exp3[f]);
        end

        // Write on the update cycle: ramp uses the old target first.
        wait_cnt(Period - 1);
        write_a(0, 42);
        for (int f = 0; f < 4; f++) begin
            measure();
            wchk($sformatf("updwr_f%0d", f), 0, 0, exp0[f]);
        end

        // Out-of-range channel index is ignored.
        repeat (20) @(negedge clk);
        write_a(4, 10);
        measure();
        wchk("oor", 0, 0, 42);
        wchk("oor", 0, 1, 50);
        wchk("oor", 0, 2, 10);
        wchk("oor", 0, 3, 50);
        check("oor_moving", 32'(moving_a), 32'd0);

        // Enable gap mid-ramp: ch1 50 -> 20, frozen at 40 during the gap.
        repeat (20) @(negedge clk);
        write_a(1, 20);
        measure();
        wchk("gap_pre", 0, 1, 45);
        repeat (30) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        check("gap_servo_first", 32'(servo_a), 32'd0);
        repeat (249) @(negedge clk);
        check("gap_servo_last", 32'(servo_a), 32'd0);
        check("gap_tick", 32'(tick_a), 32'd0);
        ena = 1'b1;
        measure();
        wchk("gap_resume0", 0, 1, 40);
        measure();
        wchk("gap_resume1", 0, 1, 35);

        // Asynchronous reset mid-frame while ch1 still ramping.
        wait_cnt(17);
        check("pre_rst_servo", 32'(servo_a), 32'hb);
        #2 rst = 1'b1;
        #1;
        check("rst_servo_a", 32'(servo_a), 32'd0);
        check("rst_servo_b", 32'(servo_b), 32'd0);
        check("rst_moving_a", 32'(moving_a), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        measure();
        for (int i = 0; i < NCh; i++) begin
            wchk("post_rst", 0, i, 30);
            wchk("post_rst", 1, i, 30);
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
